// File: rtl/vx_warp_scheduler_pkg.sv
// Shared sizing defaults and small helpers for the warp scheduler.
// Widths derive from NW/NT; PC_RESET is the boot PC of warp 0.
package vx_warp_scheduler_pkg;

    localparam int          VX_NW       = 8;
    localparam int          VX_NT       = 4;
    localparam logic [31:0] VX_PC_RESET = 32'h8000_0000;
    localparam logic [31:0] VX_PC_STEP  = 32'd4;

    function automatic logic [31:0] vx_next_pc(input logic [31:0] pc);
        return pc + VX_PC_STEP;
    endfunction

endpackage

// File: rtl/vx_warp_scheduler_rr_arbiter.sv
// Round-robin pick of one request, searching upward from ptr with wrap.
// Latency: combinational. Backpressure: none, the caller decides whether to consume the grant.
// Ready bits are qualified by the caller.
module vx_rr_arbiter #(
    parameter int NW = 8
) (
    input  logic [NW-1:0]         req,
    input  logic [$clog2(NW)-1:0] ptr,
    output logic [$clog2(NW)-1:0] grant,
    output logic                  any_grant
);
    localparam int WW = $clog2(NW);

    logic [WW-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest hit lands last.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int i = NW - 1; i >= 0; i--) begin
            idx = ptr + WW'(i);
            if (req[idx]) begin
                grant     = idx;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_warp_scheduler.sv
// Issues one ready warp per cycle to fetch; tracks active/pending/PC/mask per warp.
// Latency: one cycle state->outputs. Backpressure: in_stall freezes outputs, ptr and PC advance.
// Optional saturating perf counters under `VX_SCHED_PERF_EN (ports read 0 when undefined).
module vx_warp_scheduler
    import vx_warp_scheduler_pkg::*;
#(
    parameter int          NW       = VX_NW,
    parameter int          NT       = VX_NT,
    parameter logic [31:0] PC_RESET = VX_PC_RESET
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_stall,
    input  logic                  in_spawn_valid,
    input  logic [NW-1:0]         in_spawn_mask,
    input  logic [31:0]           in_spawn_pc,
    input  logic                  in_tmc_valid,
    input  logic [$clog2(NW)-1:0] in_tmc_warp,
    input  logic [NT-1:0]         in_tmc_mask,
    input  logic                  in_br_pend_valid,
    input  logic [$clog2(NW)-1:0] in_br_pend_warp,
    input  logic                  in_br_valid,
    input  logic [$clog2(NW)-1:0] in_br_warp,
    input  logic                  in_br_taken,
    input  logic [31:0]           in_br_dest,
    output logic                  out_fetch_valid,
    output logic [$clog2(NW)-1:0] out_warp_num,
    output logic [31:0]           out_curr_PC,
    output logic [NT-1:0]         out_valid,
    output logic                  out_busy,
    output logic [63:0]           out_perf_issue,
    output logic [63:0]           out_perf_idle
);
    localparam int WW = $clog2(NW);

    logic [NW-1:0]         active, active_n;
    logic [NW-1:0]         pend, pend_n;
    logic [NW-1:0][31:0]   pc, pc_n;
    logic [NW-1:0][NT-1:0] tmask, tmask_n;
    logic [WW-1:0]         ptr;
    logic [WW-1:0]         grant;
    logic                  any_grant;
    logic                  issue;

    vx_rr_arbiter #(.NW(NW)) u_arb (
        .req       (active & ~pend),
        .ptr       (ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    assign issue = !in_stall && any_grant;

    // Later statements win: issue +4, spawn, resolve, pend-set, then TMC.
    always_comb begin
        active_n = active;
        pend_n   = pend;
        pc_n     = pc;
        tmask_n  = tmask;
        if (issue) begin
            pc_n[grant] = vx_next_pc(pc[grant]);
        end
        if (in_spawn_valid) begin
            for (int w = 0; w < NW; w++) begin
                if (in_spawn_mask[w] && !active[w]) begin
                    active_n[w] = 1'b1;
                    pend_n[w]   = 1'b0;
                    pc_n[w]     = in_spawn_pc;
                    tmask_n[w]  = '1;
                end
            end
        end
        if (in_br_valid) begin
            pend_n[in_br_warp] = 1'b0;
            if (in_br_taken) begin
                pc_n[in_br_warp] = in_br_dest;
            end
        end
        if (in_br_pend_valid) begin
            pend_n[in_br_pend_warp] = 1'b1;
        end
        if (in_tmc_valid) begin
            tmask_n[in_tmc_warp] = in_tmc_mask;
            if (in_tmc_mask == '0) begin
                active_n[in_tmc_warp] = 1'b0;
                pend_n[in_tmc_warp]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active          <= NW'(1);
            pend            <= '0;
            pc              <= '0;
            pc[0]           <= PC_RESET;
            tmask           <= '0;
            tmask[0]        <= NT'(1);
            ptr             <= '0;
            out_fetch_valid <= 1'b0;
            out_warp_num    <= '0;
            out_curr_PC     <= '0;
            out_valid       <= '0;
            out_busy        <= 1'b0;
        end else begin
            active   <= active_n;
            pend     <= pend_n;
            pc       <= pc_n;
            tmask    <= tmask_n;
            out_busy <= |active_n;
            if (!in_stall) begin
                out_fetch_valid <= any_grant;
                if (any_grant) begin
                    out_warp_num <= grant;
                    out_curr_PC  <= pc[grant];
                    out_valid    <= tmask[grant];
                    ptr          <= grant + WW'(1);
                end
            end
        end
    end

`ifdef VX_SCHED_PERF_EN
    logic [63:0] perf_issue_q, perf_idle_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issue_q <= '0;
            perf_idle_q  <= '0;
        end else begin
            if (issue && !(&perf_issue_q)) begin
                perf_issue_q <= perf_issue_q + 64'd1;
            end
            if (!in_stall && !any_grant && !(&perf_idle_q)) begin
                perf_idle_q <= perf_idle_q + 64'd1;
            end
        end
    end

    assign out_perf_issue = perf_issue_q;
    assign out_perf_idle  = perf_idle_q;
`else
    assign out_perf_issue = '0;
    assign out_perf_idle  = '0;
`endif

endmodule
